// File: rtl/in3_bist_pkg.sv
// Shared definitions for the 3-input gate BIST controller.
// Holds the state encoding, truth tables for common gates, and vector sizing.
package in3_bist_pkg;

  localparam int unsigned IN3_VEC_W   = 3;
  localparam int unsigned IN3_NUM_VEC = 8;

  // Truth tables: bit i is the expected output for vector i = {a,b,c}
  localparam logic [7:0] IN3_NAND_TT = 8'h7F;
  localparam logic [7:0] IN3_AND_TT  = 8'h80;
  localparam logic [7:0] IN3_NOR_TT  = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } in3_bist_state_e;

  // Expected gate output for one vector of a truth table
  function automatic logic tt_bit(input logic [7:0] tt, input logic [IN3_VEC_W-1:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/in3_bist_dwell_timer.sv
// Reloadable down-counter that times how long each vector is held.
// Ports: clk, rst_n (async active-low), load (reload to DWELL-1),
//        dec (count down one), expired (count is zero).
module in3_bist_dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins; decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/in3_gate_bist_ctrl.sv
// BIST sequencer for a 3-input combinational gate: walks vectors 0..7 onto
// a/b/c, holds each DWELL cycles, samples gate_out on the last dwell cycle
// and compares against the EXPECT truth table.
// Ports: clk, rst_n (async active-low), start (level request, seen in IDLE),
//        gate_out (gate under test), a/b/c (vector MSB..LSB), busy, done
//        (one-cycle end pulse), pass (last run result), fail_vec (per-vector
//        mismatch bitmap, only when IN3_BIST_FAILMAP_EN is defined).
// Without IN3_BIST_FAILMAP_EN the error accumulator is one sticky bit.
module in3_gate_bist_ctrl
  import in3_bist_pkg::*;
#(
  parameter int unsigned DWELL  = 4,
  parameter logic [7:0]  EXPECT = IN3_NAND_TT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass
`ifdef IN3_BIST_FAILMAP_EN
  ,
  output logic [7:0] fail_vec
`endif
);

`ifdef IN3_BIST_FAILMAP_EN
  localparam int unsigned ACC_W = IN3_NUM_VEC;
`else
  localparam int unsigned ACC_W = 1;
`endif

  localparam logic [IN3_VEC_W-1:0] VEC_LAST = IN3_VEC_W'(IN3_NUM_VEC - 1);

  in3_bist_state_e state_q, state_d;
  logic [IN3_VEC_W-1:0] vec_q, vec_d;
  logic [IN3_VEC_W-1:0] abc_q, abc_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
`ifdef IN3_BIST_FAILMAP_EN
  logic [7:0]           fail_vec_q, fail_vec_d;
`endif

  logic timer_load_c;
  logic timer_dec_c;
  logic timer_expired;
  logic mismatch_c;

  in3_bist_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load_c),
    .dec     (timer_dec_c),
    .expired (timer_expired)
  );

  assign mismatch_c = (gate_out != tt_bit(EXPECT, vec_q));

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    abc_d        = abc_q;
    acc_d        = acc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
`ifdef IN3_BIST_FAILMAP_EN
    fail_vec_d   = fail_vec_q;
`endif
    timer_load_c = 1'b0;
    timer_dec_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abc_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d      = ST_APPLY;
          vec_d        = '0;
          abc_d        = '0;
          acc_d        = '0;
          busy_d       = 1'b1;
          timer_load_c = 1'b1;
        end
      end

      ST_APPLY: begin
        if (timer_expired) begin
          // Last dwell cycle: gate_out is captured at this closing edge
          if (mismatch_c) begin
`ifdef IN3_BIST_FAILMAP_EN
            acc_d[vec_q] = 1'b1;
`else
            acc_d = 1'b1;
`endif
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            abc_d   = '0;
            done_d  = 1'b1;
          end else begin
            vec_d        = vec_q + IN3_VEC_W'(1);
            abc_d        = vec_q + IN3_VEC_W'(1);
            timer_load_c = 1'b1;
          end
        end else begin
          timer_dec_c = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        abc_d   = '0;
        busy_d  = 1'b0;
        pass_d  = (acc_q == '0);
`ifdef IN3_BIST_FAILMAP_EN
        fail_vec_d = acc_q;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        abc_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      abc_q      <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef IN3_BIST_FAILMAP_EN
      fail_vec_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      abc_q      <= abc_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
`ifdef IN3_BIST_FAILMAP_EN
      fail_vec_q <= fail_vec_d;
`endif
    end
  end

  assign a    = abc_q[2];
  assign b    = abc_q[1];
  assign c    = abc_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
`ifdef IN3_BIST_FAILMAP_EN
  assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_in3_gate_bist_ctrl.sv
// Self-checking bench for in3_gate_bist_ctrl.
// u1: DWELL=4, NAND expected, gate model selectable (NAND / stuck-1 / stuck-0).
// u2: DWELL=1, NAND, start held high for back-to-back runs.
// u3: DWELL=4, EXPECT=AND table with a NAND gate attached.
module tb_in3_gate_bist_ctrl;
  import in3_bist_pkg::*;

  localparam int unsigned D1 = 4;
  localparam int unsigned D2 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [1:0] mode1 = 2'd0;
  logic a1, b1, c1, busy1, done1, pass1, gate1;
  logic a2, b2, c2, busy2, done2, pass2, gate2;
  logic a3, b3, c3, busy3, done3, pass3, gate3;
`ifdef IN3_BIST_FAILMAP_EN
  logic [7:0] fv1, fv2, fv3;
`endif

  // Gate models: mode 0 = NAND, 1 = stuck-at-1, 2 = stuck-at-0
  assign gate1 = (mode1 == 2'd0) ? ~(a1 & b1 & c1) : (mode1 == 2'd1);
  assign gate2 = ~(a2 & b2 & c2);
  assign gate3 = ~(a3 & b3 & c3);

  in3_gate_bist_ctrl #(.DWELL(D1), .EXPECT(8'h7F)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_out(gate1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1)
`ifdef IN3_BIST_FAILMAP_EN
    , .fail_vec(fv1)
`endif
  );

  in3_gate_bist_ctrl #(.DWELL(D2), .EXPECT(8'h7F)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_out(gate2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2)
`ifdef IN3_BIST_FAILMAP_EN
    , .fail_vec(fv2)
`endif
  );

  in3_gate_bist_ctrl #(.DWELL(D1), .EXPECT(8'h80)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .gate_out(gate3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3)
`ifdef IN3_BIST_FAILMAP_EN
    , .fail_vec(fv3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int         restart_cyc;
    logic       exp_pass;
    logic [7:0] exp_fv;
  } vec_t;

  vec_t tbl[4];

  // One full run on u1, checking every cycle from the first APPLY to the idle after DONE
  task automatic run1(input int idx, input logic [1:0] mode, input int restart_cyc,
                      input logic exp_pass, input logic [7:0] exp_fv);
    logic [2:0] exp_abc;
    mode1 = mode;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int cyc = 1; cyc <= int'(8 * D1 + 1); cyc++) begin
      if (cyc <= int'(8 * D1)) begin
        exp_abc = 3'((cyc - 1) / int'(D1));
        chk($sformatf("row%0d abc cyc%0d", idx, cyc), 32'({a1, b1, c1}), 32'(exp_abc));
      end
      chk($sformatf("row%0d busy/done cyc%0d", idx, cyc), 32'({busy1, done1}),
          32'({1'b1, (cyc == int'(8 * D1 + 1))}));
      start1 = (cyc == restart_cyc);
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    chk($sformatf("row%0d idle busy/done", idx), 32'({busy1, done1}), 32'(2'b00));
    chk($sformatf("row%0d pass", idx), 32'(pass1), 32'(exp_pass));
`ifdef IN3_BIST_FAILMAP_EN
    chk($sformatf("row%0d fail_vec", idx), 32'(fv1), 32'(exp_fv));
`else
    if (exp_fv == 8'hA5) $display("unreachable");
`endif
  endtask

  initial begin
    int cyc;
    int off;

    tbl[0] = '{mode: 2'd0, restart_cyc: 0,  exp_pass: 1'b1, exp_fv: 8'h00};
    tbl[1] = '{mode: 2'd1, restart_cyc: 0,  exp_pass: 1'b0, exp_fv: 8'h80};
    tbl[2] = '{mode: 2'd2, restart_cyc: 0,  exp_pass: 1'b0, exp_fv: 8'h7F};
    tbl[3] = '{mode: 2'd0, restart_cyc: 10, exp_pass: 1'b1, exp_fv: 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset abc", 32'({a1, b1, c1}), 32'(0));
    chk("reset busy/done/pass", 32'({busy1, done1, pass1}), 32'(0));
`ifdef IN3_BIST_FAILMAP_EN
    chk("reset fail_vec", 32'(fv1), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run1(i, tbl[i].mode, tbl[i].restart_cyc, tbl[i].exp_pass, tbl[i].exp_fv);
    end

    // Reset while vector 3 is applied, then a clean rerun
    mode1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k < 14; k++) begin
      @(posedge clk); #1;
    end
    chk("pre-reset abc is vec3", 32'({a1, b1, c1}), 32'(3'd3));
    rst_n = 1'b0;
    #1;
    chk("midrun reset abc", 32'({a1, b1, c1}), 32'(0));
    chk("midrun reset busy/done/pass", 32'({busy1, done1, pass1}), 32'(0));
`ifdef IN3_BIST_FAILMAP_EN
    chk("midrun reset fail_vec", 32'(fv1), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run1(9, 2'd0, 0, 1'b1, 8'h00);

    // DWELL=1 with start held high: done at 9, 19, 29
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 30; k++) begin
      off = (k - 1) % 10;
      if (off < 8)
        chk($sformatf("u2 abc cyc%0d", k), 32'({a2, b2, c2}), 32'(off));
      chk($sformatf("u2 busy/done cyc%0d", k), 32'({busy2, done2}),
          32'({(off <= 8), (off == 8)}));
      if (k == 1)
        chk("u2 pass before first run", 32'(pass2), 32'(0));
      if (off == 9)
        chk($sformatf("u2 pass cyc%0d", k), 32'(pass2), 32'(1));
      if (k == 30) start2 = 1'b0;
      @(posedge clk); #1;
    end

    // EXPECT = AND table against a NAND gate: every vector mismatches
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    cyc = 1;
    while (done3 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("u3 done cycle", 32'(cyc), 32'(33));
    @(posedge clk); #1;
    chk("u3 done single pulse", 32'(done3), 32'(0));
    chk("u3 pass", 32'(pass3), 32'(0));
`ifdef IN3_BIST_FAILMAP_EN
    chk("u3 fail_vec", 32'(fv3), 32'(8'hFF));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
